// File: rtl/obstacle_collision.sv
// Frame-synchronous obstacle scan feeding the snake motion block.
// Optional debug LEDs are enabled by defining COLL_LED_EN.
module obstacle_collision #(
    parameter int NUM_OBS = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [15:0]        keycode,
    input  logic [9:0]         BallX,
    input  logic [9:0]         BallY,
    input  logic [9:0]         BallS,
    output logic               OB1Flag,
    output logic [1:0]         motionFlag,
    output logic [NUM_OBS-1:0] hit_mask,
    output logic [9:0]         LEDR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] LAST_IDX = 2'(NUM_OBS - 1);

    logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] heading_q, heading_d;
    logic [9:0] x_q, x_d, y_q, y_d, sz_q, sz_d;
    logic [NUM_OBS-1:0] mask_q, mask_d;
    logic [NUM_OBS-1:0] hit_mask_q, hit_mask_d;
    logic ob_q, ob_d;
    logic [1:0] mf_q, mf_d;

    logic frame_rise;
    logic hit;
    logic [2:0] key_lo, key_hi;
    logic signed [11:0] xmin, xmax, ymin, ymax;
    logic signed [11:0] x_lo, x_hi, y_lo, y_hi;

    // Returns {valid, direction}
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        case (code)
            8'h1A:   decode_key = 3'b100;
            8'h04:   decode_key = 3'b101;
            8'h16:   decode_key = 3'b110;
            8'h07:   decode_key = 3'b111;
            default: decode_key = 3'b000;
        endcase
    endfunction

    assign frame_rise = s2_q & ~s3_q;
    assign key_lo = decode_key(keycode[7:0]);
    assign key_hi = decode_key(keycode[15:8]);

    always_comb begin
        case (idx_q)
            2'd0: begin
                xmin = 12'sd100; xmax = 12'sd139;
                ymin = 12'sd100; ymax = 12'sd119;
            end
            2'd1: begin
                xmin = 12'sd300; xmax = 12'sd339;
                ymin = 12'sd200; ymax = 12'sd279;
            end
            2'd2: begin
                xmin = 12'sd0;   xmax = 12'sd15;
                ymin = 12'sd60;  ymax = 12'sd179;
            end
            default: begin
                xmin = 12'sd160; xmax = 12'sd279;
                ymin = 12'sd380; ymax = 12'sd399;
            end
        endcase
    end

    // Zero-extend to 12 bits so a box hanging past the left/top edge goes negative
    assign x_lo = $signed({2'b00, x_q}) - $signed({2'b00, sz_q});
    assign x_hi = $signed({2'b00, x_q}) + $signed({2'b00, sz_q});
    assign y_lo = $signed({2'b00, y_q}) - $signed({2'b00, sz_q});
    assign y_hi = $signed({2'b00, y_q}) + $signed({2'b00, sz_q});

    assign hit = (x_hi >= xmin) && (x_lo <= xmax) &&
                 (y_hi >= ymin) && (y_lo <= ymax);

    always_comb begin
        s1_d       = frame_clk;
        s2_d       = s1_q;
        s3_d       = s2_q;
        state_d    = state_q;
        idx_d      = idx_q;
        heading_d  = heading_q;
        x_d        = x_q;
        y_d        = y_q;
        sz_d       = sz_q;
        mask_d     = mask_q;
        hit_mask_d = hit_mask_q;
        ob_d       = ob_q;
        mf_d       = mf_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_rise) begin
                    x_d  = BallX;
                    y_d  = BallY;
                    sz_d = BallS;
                    if (key_lo[2]) heading_d = key_lo[1:0];
                    if (key_hi[2]) heading_d = key_hi[1:0];
                    mask_d  = '0;
                    idx_d   = 2'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (idx_q == 2'(i)) mask_d[i] = mask_q[i] | hit;
                end
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else idx_d = idx_q + 2'd1;
            end
            ST_DONE: begin
                hit_mask_d = mask_q;
                ob_d       = |mask_q;
                mf_d       = heading_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            heading_q  <= 2'b00;
            x_q        <= '0;
            y_q        <= '0;
            sz_q       <= '0;
            mask_q     <= '0;
            hit_mask_q <= '0;
            ob_q       <= 1'b0;
            mf_q       <= 2'b00;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            heading_q  <= heading_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sz_q       <= sz_d;
            mask_q     <= mask_d;
            hit_mask_q <= hit_mask_d;
            ob_q       <= ob_d;
            mf_q       <= mf_d;
        end
    end

    assign OB1Flag    = ob_q;
    assign motionFlag = mf_q;
    assign hit_mask   = hit_mask_q;

`ifdef COLL_LED_EN
    logic [3:0] led_mask;
    always_comb begin
        led_mask = '0;
        led_mask[NUM_OBS-1:0] = hit_mask_q;
        LEDR = {ob_q, s2_q, 2'b00, mf_q, led_mask};
    end
`else
    assign LEDR = '0;
`endif

endmodule

// File: doc/obstacle_collision.md
Name: obstacle_collision

Overview:
- Sits directly upstream of the snake motion block and produces its `OB1Flag` and `motionFlag` inputs.
- Once per frame, on the rising edge of `frame_clk`, it snapshots the snake's bounding box (`BallX`, `BallY`, `BallS`) and the current heading decoded from `keycode`.
- It then scans a fixed obstacle table, one rectangle per `Clk` cycle, and registers a collision flag, a push-back direction and a per-obstacle hit mask.
- Results are stable well before the next `frame_clk` edge, where the snake block samples them.

Parameters:
- NUM_OBS, 4, number of table entries scanned, legal range 1..4; entries 0..NUM_OBS-1 are used.

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- frame_clk  input  1  frame strobe (vsync-derived), asynchronous to Clk, treated as data
- keycode  input  16  two keyboard scancodes: [7:0] and [15:8]
- BallX  input  10  snake centre X
- BallY  input  10  snake centre Y
- BallS  input  10  snake half-size
- OB1Flag  output  1  collision detected in the last completed scan
- motionFlag  output  2  heading at the snapshot: W=00, A=01, S=10, D=11
- hit_mask  output  NUM_OBS  bit i set when obstacle i overlapped in the last scan
- LEDR  output  10  debug LEDs (see Optional Feature)

Behaviour:
- Reset (async, active-high) clears:
  - OB1Flag=0, motionFlag=00, hit_mask=0, LEDR=0
  - heading=00, both synchroniser flops and the edge register, FSM=IDLE, scan index=0
- Synchroniser and edge detect:
  - frame_clk passes through a 2-flop synchroniser (s1, s2), then an edge register s3.
  - frame_rise = s2 & ~s3.
- Heading decode, evaluated at snapshot:
  - keycode[7:0] is decoded first, then keycode[15:8]; a valid code in [15:8] overrides [7:0].
  - Codes: 0x1A→00 (W), 0x04→01 (A), 0x16→10 (S), 0x07→11 (D).
  - If neither byte holds a valid code, heading is unchanged.
- Obstacle table (inclusive, pixels, listed as xmin..xmax, ymin..ymax):
  - 0: 100..139, 100..119
  - 1: 300..339, 200..279
  - 2: 0..15, 60..179
  - 3: 160..279, 380..399
- Overlap rule for obstacle i:
  - hit if (X+S ≥ xmin) && (X−S ≤ xmax) && (Y+S ≥ ymin) && (Y−S ≤ ymax).
  - All arithmetic is 12-bit signed, with inputs zero-extended, so X−S < 0 never wraps.
- FSM:
  - IDLE: on frame_rise, latch X/Y/S and heading, clear the accumulating mask, set idx=0 → SCAN.
  - SCAN: each cycle evaluate obstacle idx and OR the result into mask bit idx.
    - idx == NUM_OBS−1 → DONE; otherwise idx+1.
  - DONE: register hit_mask=mask, OB1Flag=|mask, motionFlag=heading latched at snapshot → IDLE.
- Latency: if frame_rise is first true in cycle k, the outputs change at the clock edge ending cycle k+NUM_OBS+1 (the edge at which DONE is entered from the last SCAN cycle plus one). Outputs are held constant at all other times.
- frame_rise occurring in SCAN or DONE is ignored; no queuing.
- Inputs BallX/BallY/BallS/keycode changing during SCAN have no effect (snapshot only).
- Reset asserted mid-scan aborts the scan; all outputs return to their reset values and no partial result is published.
- When the snake does not overlap any obstacle, the published values are OB1Flag=0 and hit_mask=0, and motionFlag still updates to the latched heading.

Optional Feature:
- Macro: COLL_LED_EN
- Defined:
  - LEDR[NUM_OBS−1:0] = hit_mask, with unused bits of [3:0] = 0
  - LEDR[5:4] = motionFlag
  - LEDR[8] = s2 (synchronised frame level)
  - LEDR[9] = OB1Flag
  - all other bits 0
- Undefined: LEDR is constant 0 and there is no extra logic.

Test Plan:
- Reset, then frame_clk pulse with Ball=(220,240,12), keycode=0x0000 → after NUM_OBS+3 cycles from the frame_clk rise (i.e. NUM_OBS+1 cycles from first frame_rise), OB1Flag=0, hit_mask=0000, motionFlag=00.
- Ball=(120,90,12), keycode=0x001A, frame pulse → OB1Flag=1, hit_mask=0001, motionFlag=00; the outputs do not change until the latency cycle.
- Ball=(5,100,12), keycode=0x0004 → X−S=−7 is handled as signed: hit on obstacle 2, hit_mask=0100, motionFlag=01. A wrapped (unsigned) compare would miss this hit.
- keycode=0x0407 with Ball=(320,240,12) → [15:8]=A overrides [7:0]=D: motionFlag=01, hit_mask=0010. Follow with keycode=0x00FF → heading held at 01.
- Second frame_clk pulse arriving mid-SCAN → ignored; exactly one output update occurs. A frame pulse after DONE→IDLE is accepted normally.
- Reset asserted in SCAN cycle 2 after a prior hit result → OB1Flag=0, hit_mask=0, motionFlag=00 immediately (async) and stay so until a full new scan. With COLL_LED_EN defined, LEDR[9]=OB1Flag and LEDR[5:4]=motionFlag track across all cases.
